// File: rtl/rdi_stall_sequencer.sv
// Upstream sequencer for RDI state changes: leaving Active runs a stall
// handshake (bounded by a timeout) before the new pl_state_sts is committed.
module rdi_stall_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic       lclk,
    input  logic       sys_rst,
    input  logic [3:0] i_cur_state,
    input  logic       i_tgt_valid,
    input  logic [3:0] i_tgt_state,
    output logic       o_tgt_ready,
    input  logic       i_link_error,
    output logic       o_stall_start,
    input  logic       i_pl_stallreq,
    input  logic       i_stall_done,
    output logic       o_trdy_gate,
    output logic       o_state_upd_valid,
    output logic [3:0] o_state_upd,
    output logic       o_stall_timeout,
    output logic       o_busy
);

    localparam logic [3:0] ST_ACTIVE    = 4'b0001;
    localparam logic [3:0] ST_L1        = 4'b0100;
    localparam logic [3:0] ST_L2        = 4'b1000;
    localparam logic [3:0] ST_LINKRESET = 4'b1001;
    localparam logic [3:0] ST_LINKERROR = 4'b1010;
    localparam logic [3:0] ST_RETRAIN   = 4'b1011;
    localparam logic [3:0] ST_DISABLE   = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t           state_q;
    logic [3:0]       tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_pend_q;
    logic             tgt_ready_q;
    logic             stall_start_q;
    logic             trdy_gate_q;
    logic             upd_valid_q;
    logic [3:0]       upd_q;
    logic             timeout_q;
    logic             busy_q;

    logic       req_in;
    logic [3:0] tgt_in;
    logic       stall_tgt;
    logic       need_stall;
    logic       cnt_hit;
    logic [3:0] done_state;

    // A pending internal error overrides any request and becomes the target.
    assign req_in     = i_link_error | i_tgt_valid;
    assign tgt_in     = i_link_error ? ST_LINKERROR : i_tgt_state;
    assign stall_tgt  = tgt_in inside {ST_L1, ST_L2, ST_LINKRESET,
                                       ST_LINKERROR, ST_RETRAIN, ST_DISABLE};
    assign need_stall = (i_cur_state == ST_ACTIVE) && stall_tgt;
    assign cnt_hit    = (cnt_q == CNT_LAST);
    assign done_state = (err_pend_q || i_link_error) ? ST_LINKERROR : tgt_q;

    always_ff @(posedge lclk) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            tgt_q         <= '0;
            cnt_q         <= '0;
            err_pend_q    <= 1'b0;
            tgt_ready_q   <= 1'b1;
            stall_start_q <= 1'b0;
            trdy_gate_q   <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_q         <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            upd_valid_q <= 1'b0;
            timeout_q   <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (req_in) begin
                        tgt_q <= tgt_in;
                        if (need_stall) begin
                            state_q       <= S_START;
                            cnt_q         <= '0;
                            stall_start_q <= 1'b1;
                            trdy_gate_q   <= 1'b1;
                            tgt_ready_q   <= 1'b0;
                            busy_q        <= 1'b1;
                        end else if (tgt_in != i_cur_state) begin
                            state_q     <= S_COMMIT;
                            upd_valid_q <= 1'b1;
                            upd_q       <= tgt_in;
                            tgt_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end

                S_START: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (i_link_error) begin
                        err_pend_q <= 1'b1;
                    end
                    if (cnt_hit) begin
                        state_q       <= S_COMMIT;
                        stall_start_q <= 1'b0;
                        upd_valid_q   <= 1'b1;
                        upd_q         <= ST_LINKERROR;
                        timeout_q     <= 1'b1;
                    end else if (i_pl_stallreq) begin
                        state_q       <= S_WAIT;
                        stall_start_q <= 1'b0;
                    end
                end

                // Completion beats a timeout landing on the same cycle.
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (i_link_error) begin
                        err_pend_q <= 1'b1;
                    end
                    if (i_stall_done) begin
                        state_q     <= S_COMMIT;
                        upd_valid_q <= 1'b1;
                        upd_q       <= done_state;
                    end else if (cnt_hit) begin
                        state_q     <= S_COMMIT;
                        upd_valid_q <= 1'b1;
                        upd_q       <= ST_LINKERROR;
                        timeout_q   <= 1'b1;
                    end
                end

                S_COMMIT: begin
                    state_q     <= S_IDLE;
                    err_pend_q  <= 1'b0;
                    trdy_gate_q <= 1'b0;
                    tgt_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tgt_ready       = tgt_ready_q;
    assign o_stall_start     = stall_start_q;
    assign o_trdy_gate       = trdy_gate_q;
    assign o_state_upd_valid = upd_valid_q;
    assign o_state_upd       = upd_q;
    assign o_stall_timeout   = timeout_q;
    assign o_busy            = busy_q;

endmodule

// File: tb/tb_rdi_stall_sequencer.sv
// Testbench for rdi_stall_sequencer: directed scenarios plus randomized
// transactions checked against a rule-level reference model.
module tb_rdi_stall_sequencer;

    localparam int TO = 1000;

    localparam logic [3:0] NOP    = 4'b0000;
    localparam logic [3:0] ACTIVE = 4'b0001;
    localparam logic [3:0] PMNAK  = 4'b0010;
    localparam logic [3:0] L1     = 4'b0100;
    localparam logic [3:0] L2     = 4'b1000;
    localparam logic [3:0] LRESET = 4'b1001;
    localparam logic [3:0] LERROR = 4'b1010;
    localparam logic [3:0] RETRN  = 4'b1011;
    localparam logic [3:0] DISBL  = 4'b1100;

    logic       lclk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] curState = NOP;
    logic       tgtValid = 1'b0;
    logic [3:0] tgtState = NOP;
    logic       linkError = 1'b0;
    logic       stallReq = 1'b0;
    logic       stallDone = 1'b0;

    logic       tgtReady;
    logic       stallStart;
    logic       trdyGate;
    logic       updValid;
    logic [3:0] updState;
    logic       stallTimeout;
    logic       busy;

    int checks = 0;
    int passes = 0;

    rdi_stall_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
        .lclk              (lclk),
        .sys_rst           (sys_rst),
        .i_cur_state       (curState),
        .i_tgt_valid       (tgtValid),
        .i_tgt_state       (tgtState),
        .o_tgt_ready       (tgtReady),
        .i_link_error      (linkError),
        .o_stall_start     (stallStart),
        .i_pl_stallreq     (stallReq),
        .i_stall_done      (stallDone),
        .o_trdy_gate       (trdyGate),
        .o_state_upd_valid (updValid),
        .o_state_upd       (updState),
        .o_stall_timeout   (stallTimeout),
        .o_busy            (busy)
    );

    always #5 lclk = ~lclk;

    // Status word: {stall_start, trdy_gate, busy, tgt_ready, upd_valid, timeout}
    function automatic logic [5:0] status();
        return {stallStart, trdyGate, busy, tgtReady, updValid, stallTimeout};
    endfunction

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic idle_inputs();
        tgtValid  = 1'b0;
        linkError = 1'b0;
        stallReq  = 1'b0;
        stallDone = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    // Reset asserted while a stall is in WAIT must abandon it without a commit.
    task automatic test_reset();
        logic [5:0] s;
        reset_dut();
        checks++;
        s = status();
        if (s !== 6'b000100) $display("[TB] FAIL reset_initial: got %b expected %b", s, 6'b000100);
        else passes++;
        curState = ACTIVE;
        tgtState = RETRN;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        stallReq = 1'b1;
        tick();
        stallReq = 1'b0;
        tick();
        checks++;
        s = status();
        if (s !== 6'b011000) $display("[TB] FAIL reset_pre_wait: got %b expected %b", s, 6'b011000);
        else passes++;
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            s = status();
            if (s !== 6'b000100) $display("[TB] FAIL reset_hold%0d: got %b expected %b", i, s, 6'b000100);
            else passes++;
        end
        sys_rst = 1'b0;
        tick();
        checks++;
        s = status();
        if (s !== 6'b000100) $display("[TB] FAIL reset_release: got %b expected %b", s, 6'b000100);
        else passes++;
    endtask

    task automatic test_direct();
        curState = L1;
        tgtState = ACTIVE;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        checks++;
        if ({stallStart, busy, tgtReady, updValid, updState} !== {4'b0101, ACTIVE})
            $display("[TB] FAIL direct_commit: got ss=%b busy=%b rdy=%b v=%b st=%b expected 0 1 0 1 0001",
                     stallStart, busy, tgtReady, updValid, updState);
        else passes++;
        tick();
        checks++;
        if (status() !== 6'b000100) $display("[TB] FAIL direct_after: got %b expected %b", status(), 6'b000100);
        else passes++;
    endtask

    task automatic test_stall_path();
        curState = ACTIVE;
        tgtState = RETRN;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (status() !== 6'b111000) $display("[TB] FAIL stall_launch%0d: got %b expected %b", i, status(), 6'b111000);
            else passes++;
            if (i == 0) tick();
        end
        stallReq = 1'b1;
        tick();
        stallReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (status() !== 6'b011000) $display("[TB] FAIL stall_wait%0d: got %b expected %b", i, status(), 6'b011000);
            else passes++;
            if (i < 4) tick();
        end
        stallDone = 1'b1;
        tick();
        stallDone = 1'b0;
        checks++;
        if ({status(), updState} !== {6'b011010, RETRN})
            $display("[TB] FAIL stall_commit: got %b/%b expected %b/%b", status(), updState, 6'b011010, RETRN);
        else passes++;
        tick();
        checks++;
        if (status() !== 6'b000100) $display("[TB] FAIL stall_after: got %b expected %b", status(), 6'b000100);
        else passes++;
    endtask

    task automatic test_timeout();
        int seen;
        seen = -1;
        curState = ACTIVE;
        tgtState = L2;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        stallReq = 1'b1;
        tick();
        stallReq = 1'b0;
        for (int k = 2; k <= TO + 5; k++) begin
            tick();
            if (stallTimeout === 1'b1) begin
                seen = k;
                break;
            end
        end
        checks++;
        if (seen != TO) $display("[TB] FAIL timeout_cycle: got %0d expected %0d", seen, TO);
        else passes++;
        checks++;
        if ({status(), updState} !== {6'b011011, LERROR})
            $display("[TB] FAIL timeout_commit: got %b/%b expected %b/%b", status(), updState, 6'b011011, LERROR);
        else passes++;
        tick();
        checks++;
        if (status() !== 6'b000100) $display("[TB] FAIL timeout_after: got %b expected %b", status(), 6'b000100);
        else passes++;
    endtask

    task automatic test_error_mid_stall();
        curState = ACTIVE;
        tgtState = L1;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        stallReq = 1'b1;
        tick();
        stallReq = 1'b0;
        tick();
        linkError = 1'b1;
        tick();
        linkError = 1'b0;
        tick();
        checks++;
        if (status() !== 6'b011000) $display("[TB] FAIL err_still_waiting: got %b expected %b", status(), 6'b011000);
        else passes++;
        stallDone = 1'b1;
        tick();
        stallDone = 1'b0;
        checks++;
        if ({updValid, updState} !== {1'b1, LERROR})
            $display("[TB] FAIL err_commit: got v=%b st=%b expected v=1 st=%b", updValid, updState, LERROR);
        else passes++;
        tick();
    endtask

    task automatic test_same_and_simultaneous();
        curState = ACTIVE;
        tgtState = ACTIVE;
        tgtValid = 1'b1;
        tick();
        tgtValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (status() !== 6'b000100) $display("[TB] FAIL same_state%0d: got %b expected %b", i, status(), 6'b000100);
            else passes++;
            if (i == 0) tick();
        end
        linkError = 1'b1;
        tgtState  = RETRN;
        tgtValid  = 1'b1;
        tick();
        linkError = 1'b0;
        tgtValid  = 1'b0;
        checks++;
        if (status() !== 6'b111000) $display("[TB] FAIL simul_launch: got %b expected %b", status(), 6'b111000);
        else passes++;
        stallReq = 1'b1;
        tick();
        stallReq = 1'b0;
        stallDone = 1'b1;
        tick();
        stallDone = 1'b0;
        checks++;
        if ({updValid, updState} !== {1'b1, LERROR})
            $display("[TB] FAIL simul_commit: got v=%b st=%b expected v=1 st=%b", updValid, updState, LERROR);
        else passes++;
        tick();
        curState  = L1;
        linkError = 1'b1;
        tgtValid  = 1'b1;
        tick();
        linkError = 1'b0;
        tgtValid  = 1'b0;
        checks++;
        if ({stallStart, updValid, updState} !== {2'b01, LERROR})
            $display("[TB] FAIL simul_direct: got ss=%b v=%b st=%b expected ss=0 v=1 st=%b",
                     stallStart, updValid, updState, LERROR);
        else passes++;
        tick();
    endtask

    // Reference model: target is LinkError if an error is raised with the request,
    // a stall applies only when leaving Active for a low-power/error/retrain state,
    // and an error seen during the stall turns the commit into LinkError.
    task automatic test_random();
        logic [3:0] enc [9];
        logic [3:0] c, g, reqTgt, expState;
        logic       l, stallNeeded, errMid;
        int         sDly, dDly;
        enc = '{NOP, ACTIVE, PMNAK, L1, L2, LRESET, LERROR, RETRN, DISBL};
        for (int t = 0; t < 40; t++) begin
            c       = ($urandom_range(1) == 1) ? ACTIVE : enc[$urandom_range(8)];
            g       = enc[$urandom_range(8)];
            l       = ($urandom_range(7) == 0);
            reqTgt  = l ? LERROR : g;
            stallNeeded = (c == ACTIVE) && (reqTgt inside {L1, L2, LRESET, LERROR, RETRN, DISBL});
            errMid  = stallNeeded && ($urandom_range(3) == 0);
            expState = errMid ? LERROR : reqTgt;
            sDly    = $urandom_range(3);
            dDly    = $urandom_range(5);

            checks++;
            if (tgtReady !== 1'b1) $display("[TB] FAIL rnd%0d_ready: got %b expected 1", t, tgtReady);
            else passes++;

            curState  = c;
            tgtState  = g;
            tgtValid  = 1'b1;
            linkError = l;
            tick();
            tgtValid  = 1'b0;
            linkError = 1'b0;

            if (stallNeeded) begin
                checks++;
                if ({stallStart, trdyGate, updValid} !== 3'b110)
                    $display("[TB] FAIL rnd%0d_launch: got ss=%b gate=%b v=%b expected 1 1 0", t, stallStart, trdyGate, updValid);
                else passes++;
                repeat (sDly) tick();
                stallReq = 1'b1;
                tick();
                stallReq = 1'b0;
                if (errMid) begin
                    linkError = 1'b1;
                    tick();
                    linkError = 1'b0;
                end
                repeat (dDly) tick();
                stallDone = 1'b1;
                tick();
                stallDone = 1'b0;
                checks++;
                if ({updValid, updState} !== {1'b1, expState})
                    $display("[TB] FAIL rnd%0d_stall_commit: got v=%b st=%b expected v=1 st=%b", t, updValid, updState, expState);
                else passes++;
                tick();
            end else if (reqTgt != c) begin
                checks++;
                if ({stallStart, updValid, updState} !== {2'b01, reqTgt})
                    $display("[TB] FAIL rnd%0d_direct: got ss=%b v=%b st=%b expected ss=0 v=1 st=%b",
                             t, stallStart, updValid, updState, reqTgt);
                else passes++;
                tick();
            end else begin
                checks++;
                if ({busy, updValid, stallStart} !== 3'b000)
                    $display("[TB] FAIL rnd%0d_same: got busy=%b v=%b ss=%b expected 0 0 0", t, busy, updValid, stallStart);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_stall_path();
        test_timeout();
        test_error_mid_stall();
        test_same_and_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
